// File: rtl/message_extract.sv
// Stego message extractor: gathers the LSBs of odd/even RGB pixel pairs, parses a length header
// and queues payload bytes in a show-ahead FIFO. Define EXTRACT_CHECKSUM_EN to add an XOR check byte.
module message_extract #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       HRESET,
  input  logic       start,
  input  logic       pix_valid,
  output logic       pix_ready,
  input  logic [7:0] R_O,
  input  logic [7:0] R_E,
  input  logic [7:0] G_O,
  input  logic [7:0] G_E,
  input  logic [7:0] B_O,
  input  logic [7:0] B_E,
  output logic [7:0] msg_data,
  output logic       msg_valid,
  input  logic       msg_ready,
  output logic [7:0] msg_len,
  output logic       busy,
  output logic       extract_done,
  output logic       chk_err
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
`ifdef EXTRACT_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE
  } state_e;

`ifdef EXTRACT_CHECKSUM_EN
  localparam state_e S_TAIL = S_CHECK;
`else
  localparam state_e S_TAIL = S_DONE;
`endif

  state_e      state_q, state_d;
  logic [12:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
`ifdef EXTRACT_CHECKSUM_EN
  logic [7:0]  xor_q, xor_d;
  logic        chk_q, chk_d;
`endif

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] fill_q, fill_d;
  logic        fifo_full, fifo_empty, push, pop;

  logic        beat, byte_rdy;
  logic [5:0]  bits6;
  logic [12:0] acc_sh, shifted;
  logic [3:0]  cnt_sh;
  logic [7:0]  new_byte;

  assign fifo_full  = (fill_q == DEPTH_CNT);
  assign fifo_empty = (fill_q == '0);
  assign pix_ready  = busy_q & ~fifo_full;
  assign beat       = pix_valid & pix_ready;
  assign pop        = ~fifo_empty & msg_ready;

  // Oldest bit sits highest; the accumulator never holds more than 7 bits between beats.
  assign bits6    = {R_O[0], R_E[0], G_O[0], G_E[0], B_O[0], B_E[0]};
  assign acc_sh   = {acc_q[6:0], bits6};
  assign cnt_sh   = cnt_q + 4'd6;
  assign shifted  = acc_sh >> (cnt_sh - 4'd8);
  assign new_byte = shifted[7:0];
  assign byte_rdy = beat && (cnt_sh >= 4'd8);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    push       = 1'b0;
`ifdef EXTRACT_CHECKSUM_EN
    xor_d      = xor_q;
    chk_d      = chk_q;
`endif
    if (beat) begin
      acc_d = acc_sh;
      cnt_d = byte_rdy ? (cnt_sh - 4'd8) : cnt_sh;
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_HEADER;
          acc_d      = '0;
          cnt_d      = '0;
          byte_cnt_d = '0;
`ifdef EXTRACT_CHECKSUM_EN
          xor_d      = '0;
          chk_d      = 1'b0;
`endif
        end
      end
      S_HEADER: begin
        if (byte_rdy) begin
          len_d   = new_byte;
          state_d = (new_byte == 8'd0) ? S_TAIL : S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (byte_rdy) begin
          push       = 1'b1;
          byte_cnt_d = byte_cnt_q + 8'd1;
`ifdef EXTRACT_CHECKSUM_EN
          xor_d      = xor_q ^ new_byte;
`endif
          if (byte_cnt_q + 8'd1 == len_q) state_d = S_TAIL;
        end
      end
`ifdef EXTRACT_CHECKSUM_EN
      S_CHECK: begin
        if (byte_rdy) begin
          chk_d   = (new_byte != xor_q);
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_HEADER) || (state_d == S_PAYLOAD);
`ifdef EXTRACT_CHECKSUM_EN
    if (state_d == S_CHECK) busy_d = 1'b1;
`endif
    done_d = (state_d == S_DONE);
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    fill_d   = fill_q;
    if (push && !pop)      fill_d = fill_q + (AW+1)'(1);
    else if (!push && pop) fill_d = fill_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      byte_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
`ifdef EXTRACT_CHECKSUM_EN
      xor_q      <= '0;
      chk_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
`ifdef EXTRACT_CHECKSUM_EN
      xor_q      <= xor_d;
      chk_q      <= chk_d;
`endif
    end
  end

  // NOTE: FIFO storage is not reset; the empty flag masks stale contents on msg_data.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_byte;
  end

  assign msg_valid    = ~fifo_empty;
  assign msg_data     = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign msg_len      = len_q;
  assign busy         = busy_q;
  assign extract_done = done_q;
`ifdef EXTRACT_CHECKSUM_EN
  assign chk_err      = chk_q;
`else
  assign chk_err      = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{R_O[7:1], R_E[7:1], G_O[7:1], G_E[7:1], B_O[7:1], B_E[7:1], shifted[12:8]};

endmodule

// File: tb/tb_message_extract.sv
// Directed bench for message_extract: header/payload parsing, FIFO back-pressure, reset, stray start
// and (when EXTRACT_CHECKSUM_EN is defined) the XOR check byte.
module tb_message_extract;

  logic       clk = 1'b0;
  logic       HRESET, start, pix_valid, pix_ready, msg_ready;
  logic [7:0] R_O, R_E, G_O, G_E, B_O, B_E;
  logic [7:0] msg_data, msg_len;
  logic       msg_valid, busy, extract_done, chk_err;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] rx_q[$];
  int done_pulses = 0;
  bit c_done;

  always #5 clk = ~clk;

  message_extract #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .HRESET(HRESET), .start(start), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .R_O(R_O), .R_E(R_E), .G_O(G_O), .G_E(G_E), .B_O(B_O), .B_E(B_E),
    .msg_data(msg_data), .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_len(msg_len),
    .busy(busy), .extract_done(extract_done), .chk_err(chk_err)
  );

  // Consumer side: record every popped byte and every extract_done cycle.
  always @(posedge clk) begin
    if (msg_valid && msg_ready) rx_q.push_back(msg_data);
    if (extract_done) done_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge; returns just after the falling edge following acceptance.
  task automatic send_beat(input logic [5:0] b);
    int t = 0;
    R_O = {7'($urandom), b[5]};
    R_E = {7'($urandom), b[4]};
    G_O = {7'($urandom), b[3]};
    G_E = {7'($urandom), b[2]};
    B_O = {7'($urandom), b[1]};
    B_E = {7'($urandom), b[0]};
    pix_valid = 1'b1;
    while (!pix_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!pix_ready) begin
      check("beat_timeout", 32'(pix_ready), 32'd1);
      pix_valid = 1'b0;
      start = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    pix_valid = 1'b0;
    start = 1'b0;
  endtask

  // Pulse start, then stream the message bits MSB-first. A check byte is appended when the
  // checksum build is selected. start_beat re-pulses start alongside that beat; n_beats < 0 sends all.
  task automatic run_msg(input logic [7:0] msg[$], input bit bad_chk, input int start_beat,
                         input int n_beats);
    logic [7:0] s[$];
    bit         bq[$];
    logic [7:0] x;
    logic [5:0] b6;
    int         nb;
    s = msg;
    x = 8'h00;
    for (int i = 1; i < msg.size(); i++) x = x ^ msg[i];
    if (bad_chk) x = x ^ 8'h01;
`ifdef EXTRACT_CHECKSUM_EN
    s.push_back(x);
`endif
    foreach (s[i]) for (int k = 7; k >= 0; k--) bq.push_back(s[i][k]);
    while (bq.size() % 6 != 0) bq.push_back(1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nb = bq.size() / 6;
    if (n_beats >= 0 && n_beats < nb) nb = n_beats;
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < 6; j++) b6[5-j] = bq[6*k+j];
      if (k == start_beat) start = 1'b1;
      send_beat(b6);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_pix_ready"},    32'(pix_ready),    32'd0);
    check({pfx, "_msg_valid"},    32'(msg_valid),    32'd0);
    check({pfx, "_msg_data"},     32'(msg_data),     32'd0);
    check({pfx, "_msg_len"},      32'(msg_len),      32'd0);
    check({pfx, "_busy"},         32'(busy),         32'd0);
    check({pfx, "_extract_done"}, 32'(extract_done), 32'd0);
    check({pfx, "_chk_err"},      32'(chk_err),      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    HRESET = 1'b1; start = 1'b0; pix_valid = 1'b0; msg_ready = 1'b1;
    R_O = '0; R_E = '0; G_O = '0; G_E = '0; B_O = '0; B_E = '0;
    repeat (3) @(negedge clk);
    HRESET = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // 1-byte message 0xA5
    rx_q.delete(); d0 = done_pulses;
    run_msg('{8'h01, 8'hA5}, 1'b0, -1, -1);
    check("a_done",    32'(extract_done), 32'd1);
    check("a_busy",    32'(busy),         32'd0);
    check("a_len",     32'(msg_len),      32'd1);
    check("a_chk_err", 32'(chk_err),      32'd0);
`ifndef EXTRACT_CHECKSUM_EN
    check("a_valid_k1", 32'(msg_valid), 32'd1);
    check("a_data_k1",  32'(msg_data),  32'hA5);
`endif
    @(negedge clk);
    check("a_done_fall", 32'(extract_done), 32'd0);
    check("a_rx_n",      32'(rx_q.size()),  32'd1);
    check("a_rx0",       32'(rx_q[0]),      32'hA5);
    check("a_pulses",    32'(done_pulses - d0), 32'd1);

    // zero-length header
    rx_q.delete(); d0 = done_pulses;
    run_msg('{8'h00}, 1'b0, -1, -1);
    check("z_done",  32'(extract_done), 32'd1);
    check("z_busy",  32'(busy),         32'd0);
    check("z_len",   32'(msg_len),      32'd0);
    check("z_valid", 32'(msg_valid),    32'd0);
    check("z_chk",   32'(chk_err),      32'd0);
    @(negedge clk);
    check("z_rx_n",   32'(rx_q.size()),      32'd0);
    check("z_pulses", 32'(done_pulses - d0), 32'd1);

    // back-pressure: 6 bytes into a 4-deep FIFO with the consumer stalled
    rx_q.delete(); msg_ready = 1'b0; c_done = 1'b0;
    fork
      begin
        run_msg('{8'h06, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66}, 1'b0, -1, -1);
        c_done = 1'b1;
      end
    join_none
    repeat (40) @(negedge clk);
    check("bp_pix_ready", 32'(pix_ready), 32'd0);
    check("bp_busy",      32'(busy),      32'd1);
    check("bp_valid",     32'(msg_valid), 32'd1);
    check("bp_head",      32'(msg_data),  32'h11);
    check("bp_rx_n_held", 32'(rx_q.size()), 32'd0);
    msg_ready = 1'b1;
    for (int t = 0; t < 200 && !c_done; t++) @(negedge clk);
    check("bp_finished", 32'(c_done), 32'd1);
    repeat (8) @(negedge clk);
    check("bp_rx_n", 32'(rx_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) check($sformatf("bp_rx%0d", i), 32'(rx_q[i]), 32'(8'h11 * (i + 1)));
    check("bp_len", 32'(msg_len), 32'd6);

    // reset in the middle of a payload
    rx_q.delete(); msg_ready = 1'b0;
    run_msg('{8'h03, 8'hAB, 8'hCD, 8'hEF}, 1'b0, -1, 3);
    check("mr_busy_pre",  32'(busy),      32'd1);
    check("mr_valid_pre", 32'(msg_valid), 32'd1);
    #2 HRESET = 1'b1;
    #1 check_reset_outputs("mr");
    @(negedge clk);
    HRESET = 1'b0; msg_ready = 1'b1;
    @(negedge clk);
    rx_q.delete(); d0 = done_pulses;
    run_msg('{8'h02, 8'h3C, 8'hC3}, 1'b0, -1, -1);
    check("mr_done", 32'(extract_done), 32'd1);
    check("mr_len",  32'(msg_len),      32'd2);
    repeat (2) @(negedge clk);
    check("mr_rx_n", 32'(rx_q.size()), 32'd2);
    check("mr_rx0",  32'(rx_q[0]),     32'h3C);
    check("mr_rx1",  32'(rx_q[1]),     32'hC3);

    // stray start during the payload is ignored
    rx_q.delete(); d0 = done_pulses;
    run_msg('{8'h02, 8'h5A, 8'h81}, 1'b0, 3, -1);
    check("ss_done", 32'(extract_done), 32'd1);
    check("ss_len",  32'(msg_len),      32'd2);
    repeat (2) @(negedge clk);
    check("ss_busy",   32'(busy),         32'd0);
    check("ss_rx_n",   32'(rx_q.size()),  32'd2);
    check("ss_rx0",    32'(rx_q[0]),      32'h5A);
    check("ss_rx1",    32'(rx_q[1]),      32'h81);
    check("ss_pulses", 32'(done_pulses - d0), 32'd1);

`ifdef EXTRACT_CHECKSUM_EN
    // check byte 0x26 is correct for 0x12,0x34; 0x27 is not
    rx_q.delete();
    run_msg('{8'h02, 8'h12, 8'h34}, 1'b0, -1, -1);
    check("ck_good_err", 32'(chk_err), 32'd0);
    repeat (2) @(negedge clk);
    check("ck_good_rx_n", 32'(rx_q.size()), 32'd2);
    check("ck_good_rx0",  32'(rx_q[0]),     32'h12);
    check("ck_good_rx1",  32'(rx_q[1]),     32'h34);
    rx_q.delete();
    run_msg('{8'h02, 8'h12, 8'h34}, 1'b1, -1, -1);
    check("ck_bad_err", 32'(chk_err), 32'd1);
    repeat (5) @(negedge clk);
    check("ck_bad_hold", 32'(chk_err),     32'd1);
    check("ck_bad_rx_n", 32'(rx_q.size()), 32'd2);
    check("ck_bad_rx1",  32'(rx_q[1]),     32'h34);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ck_start_clr", 32'(chk_err), 32'd0);
    HRESET = 1'b1;
    @(negedge clk);
    HRESET = 1'b0;
    @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
